fp_bin_search: RTL

//  Sequential binary-search quantizer for the play_gif pipeline.

---
 rtl/fp_bin_pkg.sv | 20 ++
 rtl/fp_ge_cmp.sv | 30 +++
 rtl/fp_bin_search.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fp_bin_pkg.sv
// Shared types and IEEE-754 single-precision field helpers for the
// binary-search quantizer.
package fp_bin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    localparam int FP_EXP_MSB = 30;
    localparam int FP_EXP_LSB = 23;
    localparam int FP_MAN_MSB = 22;

    // Quiet or signalling NaN: all-ones exponent with a non-zero mantissa.
    function automatic logic is_nan(input logic [31:0] v);
        return (v[FP_EXP_MSB:FP_EXP_LSB] == 8'hFF) && (v[FP_MAN_MSB:0] != '0);
    endfunction

endpackage

// File: rtl/fp_ge_cmp.sv
// Combinational IEEE-754 single-precision a >= b.
// Total order on sign-magnitude values; -0.0 equals +0.0; infinities order
// naturally; denormals compare exactly; any NaN operand yields false.
module fp_ge_cmp
    import fp_bin_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ge
);

    logic [31:0] key_a;
    logic [31:0] key_b;
    logic        both_zero;

    // Map each float onto an unsigned key whose integer order is the float order.
    always_comb begin
        key_a     = a[31] ? ~a : (a | 32'h8000_0000);
        key_b     = b[31] ? ~b : (b | 32'h8000_0000);
        both_zero = (a[30:0] == '0) && (b[30:0] == '0);
        if (is_nan(a) || is_nan(b)) begin
            ge = 1'b0;
        end else if (both_zero) begin
            ge = 1'b1;
        end else begin
            ge = (key_a >= key_b);
        end
    end

endmodule

// File: rtl/fp_bin_search.sv
// Sequential binary-search quantizer: maps an IEEE single sample to the
// count of programmable ascending thresholds it is >= (one compare/cycle).
// Optional feature macro: FP_BIN_NAN_FLAG_EN adds the registered out_nan flag.
module fp_bin_search
    import fp_bin_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int FP_W  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    input  logic             thr_wr_en,
    output logic             thr_wr_ready,
    input  logic [IDX_W-1:0] thr_wr_addr,
    input  logic [FP_W-1:0]  thr_wr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             busy
`ifdef FP_BIN_NAN_FLAG_EN
    ,
    output logic             out_nan
`endif
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int K_W   = (IDX_W > 1) ? $clog2(IDX_W) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [K_W-1:0]   step;
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] probe;
    logic [FP_W-1:0]  x;
    logic [FP_W-1:0]  thr [DEPTH];
    logic             ge;
    logic             accept;

    assign probe  = lo | (IDX_W'(1) << step);
    assign accept = in_valid && in_ready;

    fp_ge_cmp u_cmp (
        .a  (x),
        .b  (thr[probe]),
        .ge (ge)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_nxt    = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        thr_wr_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready     = 1'b1;
                busy         = 1'b0;
                thr_wr_ready = 1'b1;
                if (in_valid) state_nxt = SEARCH;
            end
            SEARCH: begin
                if (step == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Search datapath: latch sample, walk the index MSB-first, register result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x         <= '0;
            lo        <= '0;
            step      <= K_W'(IDX_W - 1);
            out_index <= '0;
`ifdef FP_BIN_NAN_FLAG_EN
            out_nan   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x    <= in_data;
                        lo   <= '0;
                        step <= K_W'(IDX_W - 1);
                    end
                end
                SEARCH: begin
                    if (ge) lo <= probe;
                    if (step == '0) begin
                        out_index <= ge ? probe : lo;
`ifdef FP_BIN_NAN_FLAG_EN
                        out_nan   <= is_nan(x);
`endif
                    end else begin
                        step <= step - K_W'(1);
                    end
                end
                DONE: begin
`ifdef FP_BIN_NAN_FLAG_EN
                    if (out_ready) out_nan <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    // Threshold table: writable only while idle; slot 0 is never written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the table is a small flop array, so resetting every entry is intended.
            for (int i = 0; i < DEPTH; i++) thr[i] <= '0;
        end else if (thr_wr_en && thr_wr_ready && (thr_wr_addr != '0)) begin
            thr[thr_wr_addr] <= thr_wr_data;
        end
    end

endmodule
